// File: rtl/div_seq_pkg.sv
// Shared types and constants for the tff_div_sequencer slice.
package div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned RATIO_MIN = 2;
   localparam int unsigned RATIO_RST = 2;

endpackage

// File: rtl/tff_div_sequencer_if.sv
// Ratio configuration handshake: valid/ready transfer plus illegal-ratio flag.
interface tff_div_sequencer_if #(parameter int unsigned W = 8);

   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_ratio;
   logic         cfg_err;

   modport master (output cfg_valid, output cfg_ratio, input cfg_ready, input cfg_err);
   modport slave  (input cfg_valid, input cfg_ratio, output cfg_ready, output cfg_err);

endinterface

// File: rtl/div_seq_counter.sv
// Modulo-N period counter with boundary detect and tick/tog decode.
module div_seq_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] ratio,
   output logic         boundary,
   output logic         tick,
   output logic         tog
);

   localparam logic [W:0]   ONE_X = 1;
   localparam logic [W-1:0] ONE   = 1;

   logic [W-1:0] cnt_q;
   logic [W:0]   half;

   // One extra bit so ceil(N/2) does not overflow at N = 2^W-1.
   assign half     = ({1'b0, ratio} + ONE_X) >> 1;
   assign boundary = en && (cnt_q == ratio - ONE);
   assign tick     = boundary;
   assign tog      = en && ({1'b0, cnt_q} < half);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || boundary) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + ONE;
      end
   end

endmodule

// File: rtl/tff_div_sequencer.sv
// Clock-enable divider/sequencer: FSM, ratio handshake, pending ratio.
// Optional completed-period counter enabled by defining DIV_PERIOD_CNT_EN.
module tff_div_sequencer
   import div_seq_pkg::*;
#(
   parameter int unsigned W = 8
`ifdef DIV_PERIOD_CNT_EN
 , parameter int unsigned CNT_W = 16
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   tff_div_sequencer_if.slave  cfg,
   input  logic                start,
   input  logic                stop,
   output logic                tick,
   output logic                tog,
   output logic                busy
`ifdef DIV_PERIOD_CNT_EN
 , output logic [CNT_W-1:0]    period_cnt
`endif
);

   state_t       state_q, state_d;
   logic [W-1:0] ratio_q;
   logic [W-1:0] pend_q;
   logic         pend_v;
   logic         cfg_err_q;
   logic         xfer;
   logic         legal;
   logic         start_run;
   logic         boundary;

   assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
   assign legal         = cfg.cfg_ratio >= W'(RATIO_MIN);
   assign start_run     = (state_q == IDLE) && start && !stop;
   assign cfg.cfg_ready = (state_q != DRAIN);
   assign cfg.cfg_err   = cfg_err_q;
   assign busy          = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !stop) state_d = RUN;
         RUN:     if (stop)           state_d = DRAIN;
         DRAIN:   if (boundary)       state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // A pending ratio committed at a boundary may be replaced in the same cycle
   // by a new RUN transfer, which then waits for the following boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ratio_q   <= W'(RATIO_RST);
         pend_q    <= W'(RATIO_RST);
         pend_v    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= xfer && !legal;
         if (boundary && pend_v) begin
            ratio_q <= pend_q;
            pend_v  <= 1'b0;
         end
         if (xfer && legal) begin
            if (state_q == IDLE) begin
               ratio_q <= cfg.cfg_ratio;
            end else begin
               pend_q <= cfg.cfg_ratio;
               pend_v <= 1'b1;
            end
         end
      end
   end

   div_seq_counter #(.W(W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state_q != IDLE),
      .clr      (start_run),
      .ratio    (ratio_q),
      .boundary (boundary),
      .tick     (tick),
      .tog      (tog)
   );

`ifdef DIV_PERIOD_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt <= '0;
      end else if (start_run) begin
         period_cnt <= '0;
      end else if (tick && (period_cnt != '1)) begin
         period_cnt <= period_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tff_div_sequencer.sv
// Directed self-checking bench for tff_div_sequencer.
module tb_tff_div_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic tick, tog, busy;
`ifdef DIV_PERIOD_CNT_EN
   logic [15:0] period_cnt;
`endif
   int total = 0;
   int bad = 0;

   tff_div_sequencer_if #(.W(8)) cfg_if ();

   tff_div_sequencer #(.W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg        (cfg_if.slave),
      .start      (start),
      .stop       (stop),
      .tick       (tick),
      .tog        (tog),
      .busy       (busy)
`ifdef DIV_PERIOD_CNT_EN
    , .period_cnt (period_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_to_idle();
      int n;
      stop = 1'b1;
      step();
      stop = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         step();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL drain_timeout: busy=%b want 0", busy);
      end
   endtask

   task automatic set_ratio_idle(input logic [7:0] r);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ratio = r;
      step();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({tick, tog, busy, cfg_if.cfg_ready, cfg_if.cfg_err} !== 5'b00010) begin
         bad++;
         $display("FAIL reset_outputs: tick/tog/busy/rdy/err=%b want 00010",
                  {tick, tog, busy, cfg_if.cfg_ready, cfg_if.cfg_err});
      end
`ifdef DIV_PERIOD_CNT_EN
      total++;
      if (period_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_period_cnt: got %0d want 0", period_cnt);
      end
`endif
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_n2();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         total++;
         if (tog !== (i % 2 == 0) || tick !== (i % 2 == 1) || busy !== 1'b1) begin
            bad++;
            $display("FAIL n2_cycle%0d: tog=%b tick=%b busy=%b want %b %b 1",
                     i, tog, tick, busy, (i % 2 == 0), (i % 2 == 1));
         end
         step();
      end
      drain_to_idle();
   endtask

   task automatic test_n5();
      total++;
      if (cfg_if.cfg_ready !== 1'b1) begin
         bad++;
         $display("FAIL n5_ready_idle: got %b want 1", cfg_if.cfg_ready);
      end
      set_ratio_idle(8'd5);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (tog !== ((i % 5) < 3) || tick !== ((i % 5) == 4)) begin
            bad++;
            $display("FAIL n5_cycle%0d: tog=%b tick=%b want %b %b",
                     i, tog, tick, ((i % 5) < 3), ((i % 5) == 4));
         end
`ifdef DIV_PERIOD_CNT_EN
         total++;
         if (period_cnt !== 16'(i / 5)) begin
            bad++;
            $display("FAIL n5_period_cnt%0d: got %0d want %0d", i, period_cnt, i / 5);
         end
`endif
         step();
      end
      drain_to_idle();
   endtask

   task automatic test_pending();
      set_ratio_idle(8'd4);
      start = 1'b1;
      step();
      start = 1'b0;
      // cnt 0..3 of the old 4-cycle period; 7 then 6 offered at cnt 1 and 2
      for (int i = 0; i < 4; i++) begin
         cfg_if.cfg_valid = (i == 1 || i == 2);
         cfg_if.cfg_ratio = (i == 1) ? 8'd7 : 8'd6;
         total++;
         if (tick !== (i == 3) || tog !== (i < 2) || cfg_if.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL pend_old_cnt%0d: tick=%b tog=%b rdy=%b want %b %b 1",
                     i, tick, tog, cfg_if.cfg_ready, (i == 3), (i < 2));
         end
         step();
      end
      cfg_if.cfg_valid = 1'b0;
      for (int j = 0; j < 12; j++) begin
         total++;
         if (tog !== ((j % 6) < 3) || tick !== ((j % 6) == 5)) begin
            bad++;
            $display("FAIL pend_new_cycle%0d: tog=%b tick=%b want %b %b",
                     j, tog, tick, ((j % 6) < 3), ((j % 6) == 5));
         end
         step();
      end
      drain_to_idle();
   endtask

   task automatic test_cfg_err();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ratio = 8'd1;
      step();
      cfg_if.cfg_valid = 1'b0;
      total++;
      if (cfg_if.cfg_err !== 1'b1) begin
         bad++;
         $display("FAIL err_idle_pulse: got %b want 1", cfg_if.cfg_err);
      end
      step();
      total++;
      if (cfg_if.cfg_err !== 1'b0) begin
         bad++;
         $display("FAIL err_idle_clear: got %b want 0", cfg_if.cfg_err);
      end
      // ratio stays 6 from the previous test; an illegal 0 in RUN is also discarded
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cfg_if.cfg_valid = (i == 1);
         cfg_if.cfg_ratio = 8'd0;
         total++;
         if (cfg_if.cfg_err !== (i == 2) || tick !== ((i % 6) == 5)) begin
            bad++;
            $display("FAIL err_run_cycle%0d: err=%b tick=%b want %b %b",
                     i, cfg_if.cfg_err, tick, (i == 2), ((i % 6) == 5));
         end
         step();
      end
      cfg_if.cfg_valid = 1'b0;
      drain_to_idle();
   endtask

   task automatic test_stop();
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL start_stop_idle: busy=%b want 0", busy);
      end
      set_ratio_idle(8'd4);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      stop = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b1;
      // cnt 2 in DRAIN
      total++;
      if ({busy, cfg_if.cfg_ready, tick, tog} !== 4'b1000) begin
         bad++;
         $display("FAIL stop_drain_cnt2: busy/rdy/tick/tog=%b want 1000",
                  {busy, cfg_if.cfg_ready, tick, tog});
      end
      step();
      start = 1'b0;
      total++;
      if ({busy, cfg_if.cfg_ready, tick, tog} !== 4'b1010) begin
         bad++;
         $display("FAIL stop_drain_cnt3: busy/rdy/tick/tog=%b want 1010",
                  {busy, cfg_if.cfg_ready, tick, tog});
      end
      step();
      total++;
      if ({busy, cfg_if.cfg_ready, tick, tog} !== 4'b0100) begin
         bad++;
         $display("FAIL stop_idle: busy/rdy/tick/tog=%b want 0100",
                  {busy, cfg_if.cfg_ready, tick, tog});
      end
   endtask

   task automatic test_reset_mid();
      set_ratio_idle(8'd4);
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ratio = 8'd3;
      step();
      cfg_if.cfg_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({tick, tog, busy, cfg_if.cfg_ready, cfg_if.cfg_err} !== 5'b00010) begin
         bad++;
         $display("FAIL rst_mid_outputs: tick/tog/busy/rdy/err=%b want 00010",
                  {tick, tog, busy, cfg_if.cfg_ready, cfg_if.cfg_err});
      end
`ifdef DIV_PERIOD_CNT_EN
      total++;
      if (period_cnt !== 16'd0) begin
         bad++;
         $display("FAIL rst_mid_period_cnt: got %0d want 0", period_cnt);
      end
`endif
      step();
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         total++;
         if (tog !== (i % 2 == 0) || tick !== (i % 2 == 1)) begin
            bad++;
            $display("FAIL rst_mid_n2_cycle%0d: tog=%b tick=%b want %b %b",
                     i, tog, tick, (i % 2 == 0), (i % 2 == 1));
         end
         step();
      end
      drain_to_idle();
   endtask

   initial begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ratio = 8'd0;
      test_reset();
      test_n2();
      test_n5();
      test_pending();
      test_cfg_err();
      test_stop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
